// File: rtl/cbus_rr_arbiter_pkg.sv
// rtl/cbus_rr_arbiter_pkg.sv - shared CBus request/response types and arbiter enums
package cbus_rr_arbiter_pkg;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [3:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] rdata;
   } cbus_resp_t;

   typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

   typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// rtl/cbus_rr_arbiter_if.sv - upstream/downstream CBus bundle seen by the arbiter
interface cbus_rr_arbiter_if
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int NUM_CH = 2
);
   cbus_req_t  ireqs  [NUM_CH];
   cbus_resp_t iresps [NUM_CH];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   modport master (output ireqs, output oresp, input iresps, input oreq);
   modport slave  (input ireqs, input oresp, output iresps, output oreq);
endinterface

// File: rtl/cbus_rr_arbiter_pick.sv
// rtl/cbus_rr_arbiter_pick.sv - first valid channel at or after a start index, cyclic
module cbus_arb_pick #(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]         valid,
   input  logic [$clog2(NUM_CH)-1:0] start,
   output logic [$clog2(NUM_CH)-1:0] idx,
   output logic                      found
);
   localparam int IW = $clog2(NUM_CH);

   logic [NUM_CH-1:0] rot;
   logic [IW-1:0]     off;
   logic [IW:0]       sum;

   always_comb begin
      // rot[k] is valid[(start + k) mod NUM_CH]; lowest set offset wins
      rot = NUM_CH'({valid, valid} >> start);
      off = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
      sum = {1'b0, start} + {1'b0, off};
      if (sum >= (IW+1)'(NUM_CH)) sum = sum - (IW+1)'(NUM_CH);
      idx   = sum[IW-1:0];
      found = |valid;
   end
endmodule

// File: rtl/cbus_rr_arbiter.sv
// rtl/cbus_rr_arbiter.sv - N:1 CBus arbiter holding ownership until the last beat
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int        NUM_CH = 2,
   parameter arb_mode_t MODE   = ARB_RR
) (
   input  logic                      clk,
   input  logic                      resetn,
   cbus_rr_arbiter_if.slave          bus,
   output logic [$clog2(NUM_CH)-1:0] grant_idx,
   output logic                      busy
);
   localparam int IW = $clog2(NUM_CH);

   arb_state_t        state, state_nx;
   logic [IW-1:0]     grant_nx, rr_ptr, rr_nx, pick_start, pick_idx;
   logic [NUM_CH-1:0] valid_vec;
   logic              pick_found;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) valid_vec[i] = bus.ireqs[i].valid;
      pick_start = (MODE == ARB_RR) ? rr_ptr : '0;
   end

   cbus_arb_pick #(.NUM_CH(NUM_CH)) u_pick (
      .valid (valid_vec),
      .start (pick_start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_nx;
         grant_idx <= grant_nx;
         rr_ptr    <= rr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant_idx;
      rr_nx    = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               state_nx = ST_BUSY;
               grant_nx = pick_idx;
            end
         end
         ST_BUSY: begin
            // Owner is held regardless of its valid until the final accepted beat
            if (bus.oresp.ready && bus.oresp.last) begin
               state_nx = ST_IDLE;
               if (MODE == ARB_RR)
                  rr_nx = (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == ST_BUSY);
      bus.oreq = busy ? bus.ireqs[grant_idx] : '0;
      for (int i = 0; i < NUM_CH; i++)
         bus.iresps[i] = (busy && grant_idx == IW'(i)) ? bus.oresp : '0;
   end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb/tb_cbus_rr_arbiter.sv - directed checks over fixed/rr arbiters of 2, 4 and 8 channels
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [1:0] g_f4, g_r4;
    logic       g_r2;
    logic [2:0] g_r8;
    logic       b_f4, b_r4, b_r2, b_r8;

    cbus_rr_arbiter_if #(.NUM_CH(4)) bus_f4 ();
    cbus_rr_arbiter_if #(.NUM_CH(4)) bus_r4 ();
    cbus_rr_arbiter_if #(.NUM_CH(2)) bus_r2 ();
    cbus_rr_arbiter_if #(.NUM_CH(8)) bus_r8 ();

    cbus_rr_arbiter #(.NUM_CH(4), .MODE(ARB_FIXED)) u_f4 (
        .clk(clk), .resetn(resetn), .bus(bus_f4.slave), .grant_idx(g_f4), .busy(b_f4));
    cbus_rr_arbiter #(.NUM_CH(4), .MODE(ARB_RR)) u_r4 (
        .clk(clk), .resetn(resetn), .bus(bus_r4.slave), .grant_idx(g_r4), .busy(b_r4));
    cbus_rr_arbiter #(.NUM_CH(2), .MODE(ARB_RR)) u_r2 (
        .clk(clk), .resetn(resetn), .bus(bus_r2.slave), .grant_idx(g_r2), .busy(b_r2));
    cbus_rr_arbiter #(.NUM_CH(8), .MODE(ARB_RR)) u_r8 (
        .clk(clk), .resetn(resetn), .bus(bus_r8.slave), .grant_idx(g_r8), .busy(b_r8));

    always #5 clk = ~clk;

    function automatic cbus_req_t mkreq(logic [31:0] addr, logic [3:0] len);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.len   = len;
        r.addr  = addr;
        r.wdata = ~addr;
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(logic ready, logic last, logic [31:0] rdata);
        cbus_resp_t r;
        r.ready = ready;
        r.last  = last;
        r.rdata = rdata;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin bus_f4.ireqs[i] = '0; bus_r4.ireqs[i] = '0; end
        for (int i = 0; i < 2; i++) bus_r2.ireqs[i] = '0;
        for (int i = 0; i < 8; i++) bus_r8.ireqs[i] = '0;
        bus_f4.oresp = '0; bus_r4.oresp = '0; bus_r2.oresp = '0; bus_r8.oresp = '0;

        resetn = 1'b0;
        tick(); tick();
        checks++;
        if (b_f4 !== 1'b0) begin failures++; $error("FAIL rst_f4_busy observed=%0h expected=%0h", b_f4, 1'b0); end
        checks++;
        if (g_f4 !== 2'd0) begin failures++; $error("FAIL rst_f4_grant observed=%0h expected=%0h", g_f4, 2'd0); end
        checks++;
        if (bus_f4.oreq !== cbus_req_t'('0)) begin failures++; $error("FAIL rst_f4_oreq observed=%0h expected=%0h", bus_f4.oreq, 0); end
        checks++;
        if (b_r4 !== 1'b0) begin failures++; $error("FAIL rst_r4_busy observed=%0h expected=%0h", b_r4, 1'b0); end
        checks++;
        if (b_r2 !== 1'b0) begin failures++; $error("FAIL rst_r2_busy observed=%0h expected=%0h", b_r2, 1'b0); end
        checks++;
        if (b_r8 !== 1'b0) begin failures++; $error("FAIL rst_r8_busy observed=%0h expected=%0h", b_r8, 1'b0); end
        checks++;
        if (g_r8 !== 3'd0) begin failures++; $error("FAIL rst_r8_grant observed=%0h expected=%0h", g_r8, 3'd0); end
        checks++;
        if (bus_r2.iresps[0] !== cbus_resp_t'('0)) begin failures++; $error("FAIL rst_r2_iresp0 observed=%0h expected=%0h", bus_r2.iresps[0], 0); end
        resetn = 1'b1;
        tick();

        bus_f4.ireqs[1] = mkreq(32'h100, 4'd0);
        bus_f4.ireqs[3] = mkreq(32'h300, 4'd0);
        checks++;
        if (bus_f4.oreq.valid !== 1'b0) begin failures++; $error("FAIL f4_idle_oreq_valid observed=%0h expected=%0h", bus_f4.oreq.valid, 1'b0); end
        tick();
        checks++;
        if (b_f4 !== 1'b1) begin failures++; $error("FAIL f4_busy1 observed=%0h expected=%0h", b_f4, 1'b1); end
        checks++;
        if (g_f4 !== 2'd1) begin failures++; $error("FAIL f4_grant1 observed=%0h expected=%0h", g_f4, 2'd1); end
        checks++;
        if (bus_f4.oreq.addr !== 32'h100) begin failures++; $error("FAIL f4_addr1 observed=%0h expected=%0h", bus_f4.oreq.addr, 32'h100); end
        bus_f4.oresp = mkresp(1'b1, 1'b1, 32'hAA);
        #1;
        checks++;
        if (bus_f4.iresps[1] !== mkresp(1'b1, 1'b1, 32'hAA)) begin failures++; $error("FAIL f4_iresp1 observed=%0h expected=%0h", bus_f4.iresps[1], mkresp(1'b1, 1'b1, 32'hAA)); end
        checks++;
        if (bus_f4.iresps[3] !== cbus_resp_t'('0)) begin failures++; $error("FAIL f4_iresp3_zero observed=%0h expected=%0h", bus_f4.iresps[3], 0); end
        tick();
        bus_f4.ireqs[1] = '0;
        bus_f4.oresp = '0;
        checks++;
        if (b_f4 !== 1'b0) begin failures++; $error("FAIL f4_gap_busy observed=%0h expected=%0h", b_f4, 1'b0); end
        checks++;
        if (bus_f4.oreq !== cbus_req_t'('0)) begin failures++; $error("FAIL f4_gap_oreq observed=%0h expected=%0h", bus_f4.oreq, 0); end
        tick();
        checks++;
        if (g_f4 !== 2'd3) begin failures++; $error("FAIL f4_grant3 observed=%0h expected=%0h", g_f4, 2'd3); end
        checks++;
        if (bus_f4.oreq.addr !== 32'h300) begin failures++; $error("FAIL f4_addr3 observed=%0h expected=%0h", bus_f4.oreq.addr, 32'h300); end
        bus_f4.oresp = mkresp(1'b1, 1'b1, 32'h0);
        tick();
        bus_f4.ireqs[3] = '0;
        bus_f4.oresp = '0;

        for (int i = 0; i < 4; i++) bus_r4.ireqs[i] = mkreq(32'h1000 + 32'(i), 4'd0);
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++;
            if (g_r4 !== 2'(g % 4)) begin failures++; $error("FAIL r4_grant observed=%0h expected=%0h", g_r4, 2'(g % 4)); end
            checks++;
            if (bus_r4.oreq.addr !== 32'h1000 + 32'(g % 4)) begin failures++; $error("FAIL r4_addr observed=%0h expected=%0h", bus_r4.oreq.addr, 32'h1000 + 32'(g % 4)); end
            bus_r4.oresp = mkresp(1'b1, 1'b1, 32'(g));
            tick();
            bus_r4.oresp = '0;
            checks++;
            if (b_r4 !== 1'b0) begin failures++; $error("FAIL r4_gap_busy observed=%0h expected=%0h", b_r4, 1'b0); end
        end
        for (int i = 0; i < 4; i++) bus_r4.ireqs[i] = '0;

        bus_r2.ireqs[0] = mkreq(32'h2000, 4'd3);
        tick();
        checks++;
        if (g_r2 !== 1'b0) begin failures++; $error("FAIL r2_grant0 observed=%0h expected=%0h", g_r2, 1'b0); end
        bus_r2.ireqs[1] = mkreq(32'h2100, 4'd0);
        for (int b = 0; b < 4; b++) begin
            bus_r2.oresp = mkresp(1'b1, b == 3, 32'hB0 + 32'(b));
            #1;
            checks++;
            if (bus_r2.iresps[0].rdata !== 32'hB0 + 32'(b)) begin failures++; $error("FAIL r2_beat_rdata observed=%0h expected=%0h", bus_r2.iresps[0].rdata, 32'hB0 + 32'(b)); end
            checks++;
            if (g_r2 !== 1'b0) begin failures++; $error("FAIL r2_beat_grant observed=%0h expected=%0h", g_r2, 1'b0); end
            checks++;
            if (bus_r2.iresps[1] !== cbus_resp_t'('0)) begin failures++; $error("FAIL r2_beat_iresp1 observed=%0h expected=%0h", bus_r2.iresps[1], 0); end
            tick();
        end
        bus_r2.ireqs[0] = '0;
        bus_r2.oresp = '0;
        checks++;
        if (b_r2 !== 1'b0) begin failures++; $error("FAIL r2_gap_busy observed=%0h expected=%0h", b_r2, 1'b0); end
        tick();
        checks++;
        if (g_r2 !== 1'b1) begin failures++; $error("FAIL r2_grant1 observed=%0h expected=%0h", g_r2, 1'b1); end

        bus_r2.ireqs[1] = '0;
        bus_r2.ireqs[0] = mkreq(32'h2000, 4'd0);
        bus_r2.oresp = mkresp(1'b1, 1'b0, 32'hC1);
        #1;
        checks++;
        if (bus_r2.iresps[1].rdata !== 32'hC1) begin failures++; $error("FAIL r2_drop_iresp1 observed=%0h expected=%0h", bus_r2.iresps[1].rdata, 32'hC1); end
        tick();
        checks++;
        if (b_r2 !== 1'b1) begin failures++; $error("FAIL r2_drop_busy observed=%0h expected=%0h", b_r2, 1'b1); end
        checks++;
        if (g_r2 !== 1'b1) begin failures++; $error("FAIL r2_drop_grant observed=%0h expected=%0h", g_r2, 1'b1); end
        bus_r2.oresp = mkresp(1'b0, 1'b1, 32'hC2);
        tick();
        checks++;
        if (b_r2 !== 1'b1) begin failures++; $error("FAIL r2_notready_busy observed=%0h expected=%0h", b_r2, 1'b1); end
        bus_r2.oresp = mkresp(1'b1, 1'b1, 32'hC3);
        tick();
        bus_r2.oresp = '0;
        bus_r2.ireqs[0] = '0;
        checks++;
        if (b_r2 !== 1'b0) begin failures++; $error("FAIL r2_done_busy observed=%0h expected=%0h", b_r2, 1'b0); end

        bus_r4.ireqs[2] = mkreq(32'h4200, 4'd1);
        tick();
        checks++;
        if (g_r4 !== 2'd2) begin failures++; $error("FAIL r4_own2 observed=%0h expected=%0h", g_r4, 2'd2); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (b_r4 !== 1'b0) begin failures++; $error("FAIL r4_rst_busy observed=%0h expected=%0h", b_r4, 1'b0); end
        checks++;
        if (bus_r4.oreq !== cbus_req_t'('0)) begin failures++; $error("FAIL r4_rst_oreq observed=%0h expected=%0h", bus_r4.oreq, 0); end
        bus_r4.ireqs[0] = mkreq(32'h4000, 4'd0);
        tick();
        checks++;
        if (g_r4 !== 2'd0) begin failures++; $error("FAIL r4_after_rst_grant observed=%0h expected=%0h", g_r4, 2'd0); end
        bus_r4.oresp = mkresp(1'b1, 1'b1, 32'h0);
        tick();
        bus_r4.oresp = '0;
        bus_r4.ireqs[0] = '0;
        bus_r4.ireqs[2] = '0;

        bus_r8.ireqs[7] = mkreq(32'h8700, 4'd0);
        tick();
        checks++;
        if (g_r8 !== 3'd7) begin failures++; $error("FAIL r8_grant7 observed=%0h expected=%0h", g_r8, 3'd7); end
        bus_r8.oresp = mkresp(1'b1, 1'b1, 32'h0);
        tick();
        bus_r8.oresp = '0;
        bus_r8.ireqs[7] = '0;
        bus_r8.ireqs[0] = mkreq(32'h8000, 4'd0);
        bus_r8.ireqs[6] = mkreq(32'h8600, 4'd0);
        tick();
        checks++;
        if (g_r8 !== 3'd0) begin failures++; $error("FAIL r8_wrap_grant observed=%0h expected=%0h", g_r8, 3'd0); end
        checks++;
        if (bus_r8.oreq.addr !== 32'h8000) begin failures++; $error("FAIL r8_wrap_addr observed=%0h expected=%0h", bus_r8.oreq.addr, 32'h8000); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cbus_rr_arbiter.md
CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of upstream CBus channels (legal range 2..8).
REQ-002 SHALL have parameter MODE, default ARB_RR, meaning arbitration policy (ARB_FIXED: lowest index wins; ARB_RR: round-robin).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port ireqs  input  NUM_CH x cbus_req_t  upstream requests.
REQ-006 SHALL have port iresps  output  NUM_CH x cbus_resp_t  upstream responses.
REQ-007 SHALL have port oreq  output  cbus_req_t  downstream request.
REQ-008 SHALL have port oresp  input  cbus_resp_t  downstream response.
REQ-009 SHALL have port grant_idx  output  $clog2(NUM_CH)  index of the owning channel, valid while busy.
REQ-010 SHALL have port busy  output  1  high while a transaction is owned.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE, with any ireqs[i].valid high, SHALL select a winner combinationally, register it into grant_idx, and enter BUSY at the next edge.
REQ-013 In IDLE with no valid request, SHALL remain in IDLE.
REQ-014 ARB_FIXED: SHALL pick the lowest valid index.
REQ-015 ARB_RR: SHALL search cyclically from pointer rr_ptr and pick the first valid index, wrapping NUM_CH-1 -> 0.
REQ-016 rr_ptr SHALL update to (grant_idx+1) mod NUM_CH on transaction completion only, and SHALL be unused under ARB_FIXED.
REQ-017 oreq SHALL equal ireqs[grant_idx] in BUSY and all-zero in IDLE; arbitration latency is one cycle from valid to oreq.valid.
REQ-018 iresps[grant_idx] SHALL equal oresp in BUSY; every other iresps entry, and all entries in IDLE, SHALL be all-zero.
REQ-019 Completion SHALL be the cycle with BUSY, oresp.ready=1 and oresp.last=1; at the next edge the FSM SHALL return to IDLE.
REQ-020 After completion the FSM SHALL spend at least one cycle in IDLE before the next grant; there is no back-to-back grant.
REQ-021 The grant SHALL NOT change during BUSY regardless of other channels' valid, including when the owner deasserts valid (protocol violation; ownership held until completion).
REQ-022 Multi-beat bursts (len > 0) SHALL stay on one channel until the last beat.
REQ-023 busy SHALL be 1 exactly in BUSY.

Reset
REQ-024 With resetn=0 at an edge: state=IDLE, grant_idx=0, rr_ptr=0.
REQ-025 During and after reset, oreq and all iresps SHALL be zero and busy=0 from the cycle after the reset edge.
REQ-026 Reset mid-transaction SHALL abandon ownership with no completion and no rr_ptr advance.

Structure
REQ-027 cbus_req_t and cbus_resp_t SHALL come from the existing shared bus package; a new enum arb_mode_t {ARB_FIXED, ARB_RR} SHALL be added to the same package.
REQ-028 Winner selection SHALL be one combinational sub-module, cbus_arb_pick (inputs: valid vector, start pointer; outputs: index, found).
REQ-029 The design SHALL target 120-400 lines total and SHALL contain no latches.

Verification
REQ-030 NUM_CH=4, ARB_FIXED: ch1 and ch3 valid in the same cycle -> grant_idx=1 and oreq.addr=ch1 addr next cycle; ch3 is granted after ch1 completes, following one IDLE cycle.
REQ-031 NUM_CH=4, ARB_RR: all four channels held valid continuously -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-032 NUM_CH=2: ch0 issues len=3 burst and ch1 asserts valid mid-burst -> 4 beats all routed to ch0, iresps[1] stays zero until ch1 is granted.
REQ-033 Owner drops valid mid-burst -> busy stays 1 and grant_idx unchanged until oresp.last with oresp.ready.
REQ-034 resetn=0 for one cycle during BUSY on ch2 -> next cycle busy=0, oreq=0, and rr_ptr=0, so with ch0 and ch2 valid the next grant is ch0.
REQ-035 NUM_CH=8, ARB_RR, grant on ch7 completes -> rr_ptr wraps to 0, and with ch0 and ch6 valid the next grant is ch0.
